window_data_mover: RTL

//  Parametrised successor data mover: walks every KHxKW window of an IMG_H x IMG_W image held in a feature BRAM.

---
 rtl/window_data_mover.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/window_data_mover.sv
// Window data mover: fetches every KHxKW window of an image from a 1-cycle BRAM,
// tap by tap, and presents the assembled window on a valid/ready stream.

module window_data_mover_slot #(
  parameter int DWIDTH = 32,
  parameter int TW     = 5,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [TW-1:0]     wr_idx_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] q_o
);
  logic [DWIDTH-1:0] slot_q;

  always_ff @(posedge clk) begin
    if (!rst)                                    slot_q <= '0;
    else if (wr_en_i && (wr_idx_i == TW'(IDX)))  slot_q <= wdata_i;
  end

  assign q_o = slot_q;
endmodule

module window_data_mover #(
  parameter  int KW     = 5,
  parameter  int KH     = 5,
  parameter  int D_BW   = 8,
  parameter  int CH     = 4,
  parameter  int AWIDTH = 6,
  parameter  int IMG_W  = 8,
  parameter  int IMG_H  = 8,
  parameter  int STRIDE = 1,
  localparam int DWIDTH = CH * D_BW,
  localparam int OW     = (IMG_W - KW) / STRIDE + 1,
  localparam int OH     = (IMG_H - KH) / STRIDE + 1,
  localparam int XW     = $clog2(OW) + 1,
  localparam int YW     = $clog2(OH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_run,
  input  logic [AWIDTH-1:0]        i_base_addr,
  output logic                     o_mem_en,
  output logic [AWIDTH-1:0]        o_mem_addr,
  input  logic [DWIDTH-1:0]        i_mem_rdata,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [KH*KW*DWIDTH-1:0]  o_data,
  output logic [XW-1:0]            o_win_x,
  output logic [YW-1:0]            o_win_y,
  output logic                     o_busy,
  output logic                     o_done
);
  localparam int NTAP = KH * KW;
  localparam int KXW  = (KW > 1) ? $clog2(KW) : 1;
  localparam int KYW  = (KH > 1) ? $clog2(KH) : 1;
  localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [AWIDTH-1:0]             base_q, base_d;
  logic [KXW-1:0]                kx_q, kx_d;
  logic [KYW-1:0]                ky_q, ky_d;
  logic [XW-1:0]                 wx_q, wx_d;
  logic [YW-1:0]                 wy_q, wy_d;
  logic [AWIDTH-1:0]             addr_q, addr_d;
  logic                          cap_en_q;
  logic [TW-1:0]                 cap_idx_q;
  logic [NTAP-1:0][DWIDTH-1:0]   win;
  logic                          last_tap, last_win;

  assign last_tap = (kx_q == KXW'(KW - 1)) && (ky_q == KYW'(KH - 1));
  assign last_win = (wx_q == XW'(OW - 1)) && (wy_q == YW'(OH - 1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    unique case (state_q)
      S_IDLE: if (i_run) begin
        state_d = S_FETCH;
        base_d  = i_base_addr;
        kx_d    = '0;
        ky_d    = '0;
        wx_d    = '0;
        wy_d    = '0;
      end
      S_FETCH: begin
        if (last_tap) begin
          state_d = S_DRAIN;
          kx_d    = '0;
          ky_d    = '0;
        end else if (kx_q == KXW'(KW - 1)) begin
          kx_d = '0;
          ky_d = ky_q + KYW'(1);
        end else begin
          kx_d = kx_q + KXW'(1);
        end
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: if (i_ready) begin
        if (last_win) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          if (wx_q == XW'(OW - 1)) begin
            wx_d = '0;
            wy_d = wy_q + YW'(1);
          end else begin
            wx_d = wx_q + XW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address follows the next-state counters so it lands with the tap it names.
  always_comb begin
    addr_d = base_d + AWIDTH'((32'(wy_d) * STRIDE + 32'(ky_d)) * IMG_W
                              + 32'(wx_d) * STRIDE + 32'(kx_d));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q    <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      addr_q    <= '0;
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      base_q    <= base_d;
      kx_q      <= kx_d;
      ky_q      <= ky_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      if (state_d == S_FETCH) addr_q <= addr_d;
      cap_en_q  <= (state_q == S_FETCH);
      cap_idx_q <= TW'(32'(ky_q) * KW + 32'(kx_q));
    end
  end

  for (genvar t = 0; t < NTAP; t++) begin : g_tap
    window_data_mover_slot #(.DWIDTH(DWIDTH), .TW(TW), .IDX(t)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_en_i (cap_en_q),
      .wr_idx_i(cap_idx_q),
      .wdata_i (i_mem_rdata),
      .q_o     (win[t])
    );
  end

  always_comb begin
    o_mem_en = (state_q == S_FETCH);
    o_valid  = (state_q == S_OUT);
    o_busy   = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_OUT);
    o_done   = (state_q == S_DONE);
  end

  assign o_mem_addr = addr_q;
  assign o_data     = win;
  assign o_win_x    = wx_q;
  assign o_win_y    = wy_q;
endmodule
